// File: rtl/apb4_completer_regbank.sv
// APB4 completer with a word-addressed register bank, programmable wait states,
// byte-lane writes and PPROT access checks; errored transfers are counted.
module apb4_completer_regbank #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter bit          SECURE_ONLY = 1'b0,
    parameter bit          PRIV_ONLY   = 1'b0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B40001
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [11:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    input  logic [2:0]  PPROT,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  err_count
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      r_state;
    logic [11:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic [1:0]  r_prot;
    logic [3:0]  r_wait;
    logic [7:0]  r_err_count;
    logic [31:0] r_regs [1:NUM_REGS-1];

    logic [9:0]  w_idx;
    logic        w_complete;
    logic        w_err;
    logic        w_wr_ok;
    logic [31:0] w_rd_val;
    logic        w_unused;

    // Instruction/data attribute carries no meaning for this bank.
    assign w_unused = PPROT[2];

    assign w_idx      = r_addr[11:2];
    assign w_complete = (r_state == S_ACCESS) && PSEL && PENABLE && (r_wait == 4'd0);
    assign w_err      = ({20'd0, r_addr} >= 32'(NUM_REGS * 4))
                      || (r_addr[1:0] != 2'b00)
                      || (SECURE_ONLY && r_prot[1])
                      || (PRIV_ONLY && !r_prot[0])
                      || (r_write && (w_idx == 10'd0));
    assign w_wr_ok    = w_complete && !w_err && r_write;

    always_comb begin
        w_rd_val = '0;
        if (w_idx == 10'd0) w_rd_val = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_idx == 10'(i)) w_rd_val = r_regs[i];
        end
    end

    assign PREADY    = w_complete;
    assign PSLVERR   = w_complete && w_err;
    assign PRDATA    = (w_complete && !w_err && !r_write) ? w_rd_val : 32'd0;
    assign err_count = r_err_count;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_addr  <= PADDR;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        r_prot  <= PPROT[1:0];
                        r_wait  <= 4'(WAIT_STATES);
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!PSEL) begin
                        r_state <= S_IDLE;
                    end else if (PENABLE) begin
                        if (r_wait != 4'd0) r_wait  <= r_wait - 4'd1;
                        else                r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_count <= '0;
            for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_complete && w_err && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_ok && (w_idx == 10'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_strb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_completer_regbank.sv
// Directed bench: dut0 uses default parameters, dut1 adds wait states and
// secure/privileged-only access on the same shared APB signals.
module tb_apb4_completer_regbank;

    logic        clk;
    logic        rst_n;
    logic        psel0, psel1, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [7:0]  err0, err1;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] ID = 32'hA5B40001;

    apb4_completer_regbank dut0 (
        .HCLK(clk), .HRESETn(rst_n), .PSEL(psel0), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .err_count(err0)
    );

    apb4_completer_regbank #(
        .WAIT_STATES(3), .SECURE_ONLY(1'b1), .PRIV_ONLY(1'b1)
    ) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .PSEL(psel1), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata1), .PREADY(pready1),
        .PSLVERR(pslverr1), .err_count(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Leaves PSEL/PENABLE asserted after completion so a following call is back-to-back.
    task automatic apb_xfer(input int sel, input logic wr, input logic [11:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, output logic [31:0] rdata,
                            output logic slverr, output int cycles, output int lows);
        @(posedge clk); #1;
        psel0 = (sel == 0); psel1 = (sel == 1); penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles = 1; lows = 0; rdata = '0; slverr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycles++;
            @(negedge clk);
            if ((sel == 0) ? pready0 : pready1) begin
                rdata  = (sel == 0) ? prdata0 : prdata1;
                slverr = (sel == 0) ? pslverr0 : pslverr1;
                return;
            end
            lows++;
            @(posedge clk); #1;
        end
        check("pready_timeout", 32'd0, 32'd1);
    endtask

    task automatic apb_idle();
        @(posedge clk); #1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        se;
    int          cyc, lw;

    initial begin
        rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        #12;
        check("rst_pready",  32'(pready0),  32'd0);
        check("rst_pslverr", 32'(pslverr0), 32'd0);
        check("rst_prdata",  prdata0,       32'd0);
        check("rst_errcnt",  32'(err0),     32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic reads on dut0
        apb_xfer(0, 0, 12'h000, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("id_data", rd, ID);
        check("id_err", 32'(se), 32'd0);
        check("id_cycles", 32'(cyc), 32'd2);
        apb_xfer(0, 0, 12'h004, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("r1_reset", rd, 32'd0);

        // Byte-lane writes, then back-to-back read of the same register
        apb_xfer(0, 1, 12'h008, 32'hDEADBEEF, 4'b1111, 3'b001, rd, se, cyc, lw);
        check("wr_full_err", 32'(se), 32'd0);
        apb_xfer(0, 1, 12'h008, 32'h11223344, 4'b0101, 3'b001, rd, se, cyc, lw);
        apb_xfer(0, 0, 12'h008, 0, 4'h0, 3'b001, rd, se, cyc, lw);
        check("strb_merge", rd, 32'hDE22BE44);
        apb_xfer(0, 1, 12'h008, 32'hFFFFFFFF, 4'b0000, 3'b001, rd, se, cyc, lw);
        check("strb0_err", 32'(se), 32'd0);
        apb_xfer(0, 0, 12'h008, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("strb0_noop", rd, 32'hDE22BE44);
        apb_xfer(0, 1, 12'h03C, 32'h0BADF00D, 4'b1111, 3'b001, rd, se, cyc, lw);
        apb_xfer(0, 0, 12'h03C, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("last_reg", rd, 32'h0BADF00D);

        // Error responses on dut0
        apb_xfer(0, 0, 12'h040, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("oor_err", 32'(se), 32'd1);
        check("oor_data", rd, 32'd0);
        apb_xfer(0, 1, 12'h006, 32'h12345678, 4'hF, 3'b001, rd, se, cyc, lw);
        check("misalign_err", 32'(se), 32'd1);
        apb_xfer(0, 1, 12'h000, 32'h12345678, 4'hF, 3'b001, rd, se, cyc, lw);
        check("ro_err", 32'(se), 32'd1);
        apb_idle();
        check("errcnt_3", 32'(err0), 32'd3);
        apb_xfer(0, 0, 12'h000, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("id_kept", rd, ID);
        apb_xfer(0, 0, 12'h004, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("r1_after_misalign", rd, 32'd0);

        // Wait states on dut1
        apb_xfer(1, 0, 12'h000, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("ws_lows", 32'(lw), 32'd3);
        check("ws_cycles", 32'(cyc), 32'd5);
        check("ws_data", rd, ID);

        // Abort after one ACCESS cycle
        @(posedge clk); #1;
        psel0 = 1'b0; psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h004; pwdata = 32'h55555555; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        check("abort_pready", 32'(pready1), 32'd0);
        @(posedge clk); #1; psel1 = 1'b0; penable = 1'b0;
        apb_xfer(1, 0, 12'h004, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("abort_noupd", rd, 32'd0);
        apb_idle();
        check("abort_errcnt", 32'(err1), 32'd0);

        // Secure/privileged checks on dut1
        apb_xfer(1, 1, 12'h004, 32'h12345678, 4'hF, 3'b011, rd, se, cyc, lw);
        check("nonsec_err", 32'(se), 32'd1);
        apb_xfer(1, 1, 12'h004, 32'h12345678, 4'hF, 3'b000, rd, se, cyc, lw);
        check("unpriv_err", 32'(se), 32'd1);
        apb_xfer(1, 0, 12'h004, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("prot_noupd", rd, 32'd0);
        apb_xfer(1, 1, 12'h004, 32'h12345678, 4'hF, 3'b001, rd, se, cyc, lw);
        check("prot_ok_err", 32'(se), 32'd0);
        apb_xfer(1, 0, 12'h004, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("prot_ok_data", rd, 32'h12345678);
        apb_idle();
        check("prot_errcnt", 32'(err1), 32'd2);

        // Saturation: 3 + 260 errors on dut0
        for (int n = 0; n < 260; n++)
            apb_xfer(0, 0, 12'h040, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        apb_idle();
        check("errcnt_sat", 32'(err0), 32'd255);

        // Reset during the completion cycle of a write
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h010; pwdata = 32'hAAAAAAAA; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        check("pre_rst_pready", 32'(pready0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pready",  32'(pready0),  32'd0);
        check("mid_rst_pslverr", 32'(pslverr0), 32'd0);
        check("mid_rst_errcnt",  32'(err0),     32'd0);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        apb_xfer(0, 0, 12'h010, 0, 4'hF, 3'b001, rd, se, cyc, lw);
        check("rst_write_dropped", rd, 32'd0);
        apb_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb4_completer_regbank.md
Name: apb4_completer_regbank

Overview:
APB4 completer (slave) at the far end of the shared APB bus driven by the AHB-to-APB bridge. It provides a word-addressed register bank with configurable wait states, PSTRB byte-lane writes, and PPROT-based secure/privilege access checks. Errors are reported on PSLVERR. It is the bus target the transaction generator exercises through the bridge, one instance per PSEL bit.

Parameters:
NUM_REGS, 16, number of 32-bit registers; legal offsets 0..NUM_REGS*4-4; range 2..256.
WAIT_STATES, 0, extra ACCESS cycles with PREADY low before completion; range 0..15.
SECURE_ONLY, 0, 1 = any access with PPROT[1]=1 (non-secure) errors.
PRIV_ONLY, 0, 1 = any access with PPROT[0]=0 (unprivileged) errors.
ID_VALUE, 32'hA5B40001, constant read value of register 0 (read-only).

Ports:
HCLK  in  1  clock
HRESETn  in  1  async active-low reset
PSEL  in  1  completer select (one bit of the bridge PSEL vector)
PENABLE  in  1  APB access phase
PADDR  in  12  byte offset within the 4 KB peripheral window
PWRITE  in  1  1 = write
PWDATA  in  32  write data
PSTRB  in  4  write byte strobes
PPROT  in  3  [0] privileged, [1] non-secure, [2] instruction
PRDATA  out  32  read data
PREADY  out  1  transfer completion
PSLVERR  out  1  error response, valid only with PREADY
err_count  out  8  saturating count of errored transfers

Behaviour:
- Reset is HRESETn, asynchronous, active-low; the clock is HCLK.
- Reset values: FSM IDLE; PREADY=0, PSLVERR=0, PRDATA=0, err_count=0; registers 1..N-1 = 0.
- Reset mid-transfer returns the FSM to IDLE immediately. A pending write is discarded and no count is recorded.
- FSM states: IDLE, ACCESS.
- IDLE: on PSEL=1 and PENABLE=0 (setup phase):
  - capture PADDR, PWRITE, PWDATA, PSTRB, PPROT;
  - load wait counter = WAIT_STATES;
  - go to ACCESS.
- IDLE with PSEL=1 and PENABLE=1 (no setup phase) is ignored and the FSM stays in IDLE.
- ACCESS with PSEL=1 and PENABLE=1:
  - counter != 0: decrement, PREADY=0;
  - counter == 0: PREADY=1 (completion cycle), then return to IDLE on the next edge.
- ACCESS with PSEL=0 (abort): return to IDLE, no write, no err_count change.
- PREADY, PSLVERR and PRDATA are combinational from state and captured values. All three are 0 outside the completion cycle.
- Latency from the setup-phase cycle to completion is WAIT_STATES+1 cycles. WAIT_STATES=0 gives a standard 2-cycle APB transfer.
- Back-to-back transfers: a new setup phase is accepted in the cycle immediately after completion.
- Error conditions are evaluated on the captured values. Any one of these sets PSLVERR=1 in the completion cycle:
  - offset >= NUM_REGS*4;
  - PADDR[1:0] != 0;
  - SECURE_ONLY and PPROT[1]=1;
  - PRIV_ONLY and PPROT[0]=0;
  - a write to register 0.
- Errored transfer: no register update, PRDATA=0, err_count increments at the completion edge and saturates at 255.
- Write OKAY: at the completion edge, byte lane b of register PADDR[..:2] is updated from PWDATA iff PSTRB[b]. PSTRB=4'b0000 is a legal no-op with OKAY response.
- Read OKAY: PRDATA = register value (ID_VALUE for index 0). PSTRB is ignored on reads.
- A read that follows a write to the same register returns the new value (the write commits before the next setup phase).

Test Plan:
- Reset, then read offset 0x000 (PPROT=3'b001) -> completes in 2 cycles, PRDATA=32'hA5B40001, PSLVERR=0; read 0x004 -> PRDATA=0.
- Write 0x008 = 32'hDEADBEEF with PSTRB=4'b1111, then write 32'h11223344 with PSTRB=4'b0101, then read 0x008 -> PRDATA=32'hDE22BE44.
- WAIT_STATES=3: any read -> PREADY low for 3 ACCESS cycles, high on the 4th; PSEL dropped after 1 ACCESS cycle -> abort, register unchanged, err_count=0.
- Read 0x040 (NUM_REGS=16), write 0x006, write 0x000 -> each gives PSLVERR=1 with PREADY=1, PRDATA=0, err_count=3, register 0 still reads ID_VALUE.
- SECURE_ONLY=1, PRIV_ONLY=1: write 0x004 with PPROT=3'b011 -> PSLVERR=1, reg unchanged; PPROT=3'b000 -> PSLVERR=1; PPROT=3'b001 -> OKAY, write applied.
- 260 errored transfers -> err_count=255, no wrap; assert HRESETn mid-ACCESS of a write -> outputs 0 immediately, register keeps its old value.
